// File: rtl/rf_alu_sequencer_if.sv
// Instruction handshake between fetch and the RF+ALU sequencer.
// Fetch side is master, sequencer is slave.
interface rf_alu_sequencer_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/rf_alu_sequencer.sv
// Three-state controller sequencing the RF+ALU datapath.
// Owns the architectural C/Z/N/V flag register.
module rf_alu_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    rf_alu_sequencer_if.slave ibus,
    input  logic [DATA_W-1:0] Y,
    input  logic              Z,
    input  logic              N,
    input  logic              C,
    input  logic              V,
    output logic [ADDR_W-1:0] Read_Addr_A,
    output logic [ADDR_W-1:0] Read_Addr_B,
    output logic              Src_ALU_B,
    output logic [4:0]        imm5,
    output logic              ADC,
    output logic              SUB,
    output logic              SBB,
    output logic              Pre_C,
    output logic              Write_En,
    output logic [ADDR_W-1:0] Write_Addr,
    output logic [DATA_W-1:0] Write_Data,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v,
    output logic              done,
    output logic              illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic [3:0]          cap_q, cap_d;
    logic [3:0]          flg_q, flg_d;

    logic [3:0] op;
    logic       legal;
    logic       is_adc;
    logic       is_sub;
    logic       is_sbb;
    logic       is_imm;

    assign op     = ir_q[15:12];
    assign legal  = (op <= 4'd6);
    assign is_adc = (op == 4'd1);
    assign is_sbb = (op == 4'd3);
    assign is_sub = (op == 4'd2) || (op == 4'd5) || (op == 4'd6);
    assign is_imm = (op == 4'd4) || (op == 4'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            y_q     <= '0;
            cap_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            y_q     <= y_d;
            cap_q   <= cap_d;
            flg_q   <= flg_d;
        end
    end

    // Illegal ops walk EXEC/WB but never touch result or flag state.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        y_d     = y_q;
        cap_d   = cap_q;
        flg_d   = flg_q;
        case (state_q)
            S_IDLE: begin
                if (ibus.instr_valid) begin
                    ir_d    = ibus.instr;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (legal) begin
                    y_d   = Y;
                    cap_d = {C, Z, N, V};
                end
                state_d = S_WB;
            end
            S_WB: begin
                if (legal) flg_d = cap_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ibus.instr_ready = (state_q == S_IDLE);

    always_comb begin
        Read_Addr_A = '0;
        Read_Addr_B = '0;
        Src_ALU_B   = 1'b0;
        imm5        = '0;
        ADC         = 1'b0;
        SUB         = 1'b0;
        SBB         = 1'b0;
        Pre_C       = 1'b0;
        Write_En    = 1'b0;
        Write_Addr  = '0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_EXEC: begin
                Read_Addr_A = ir_q[8:6];
                Read_Addr_B = ir_q[5:3];
                imm5        = ir_q[4:0];
                Src_ALU_B   = is_imm;
                unique case (1'b1)
                    is_adc: begin
                        ADC   = 1'b1;
                        Pre_C = flg_q[3];
                    end
                    is_sbb: begin
                        SBB   = 1'b1;
                        Pre_C = flg_q[3];
                    end
                    is_sub: SUB = 1'b1;
                    default: ;
                endcase
            end
            S_WB: begin
                Write_En   = (op <= 4'd5);
                Write_Addr = ir_q[11:9];
                done       = 1'b1;
                illegal    = !legal;
            end
            default: ;
        endcase
    end

    assign Write_Data = y_q;
    assign flag_c     = flg_q[3];
    assign flag_z     = flg_q[2];
    assign flag_n     = flg_q[1];
    assign flag_v     = flg_q[0];

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Scoreboard bench: behavioural RF+ALU around the sequencer,
// expected retire results queued at issue and checked at done.
module tb_rf_alu_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_alu_sequencer_if ibus ();

    logic [15:0] Y;
    logic        Z, N, C, V;
    logic [2:0]  Read_Addr_A, Read_Addr_B, Write_Addr;
    logic        Src_ALU_B;
    logic [4:0]  imm5;
    logic        ADC, SUB, SBB, Pre_C, Write_En;
    logic [15:0] Write_Data;
    logic        flag_c, flag_z, flag_n, flag_v;
    logic        done, illegal;

    rf_alu_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ibus(ibus.slave),
        .Y(Y),
        .Z(Z),
        .N(N),
        .C(C),
        .V(V),
        .Read_Addr_A(Read_Addr_A),
        .Read_Addr_B(Read_Addr_B),
        .Src_ALU_B(Src_ALU_B),
        .imm5(imm5),
        .ADC(ADC),
        .SUB(SUB),
        .SBB(SBB),
        .Pre_C(Pre_C),
        .Write_En(Write_En),
        .Write_Addr(Write_Addr),
        .Write_Data(Write_Data),
        .flag_c(flag_c),
        .flag_z(flag_z),
        .flag_n(flag_n),
        .flag_v(flag_v),
        .done(done),
        .illegal(illegal)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file with a bench preload port
    logic [15:0] rf [8];
    logic        pl_en;
    logic [2:0]  pl_a;
    logic [15:0] pl_d;
    always @(posedge clk) begin
        if (pl_en) rf[pl_a] <= pl_d;
        else if (Write_En) rf[Write_Addr] <= Write_Data;
    end

    // ALU per the datapath contract
    logic [15:0] dp_a, dp_b;
    logic [16:0] dp_s;
    always_comb begin
        dp_a = rf[Read_Addr_A];
        dp_b = Src_ALU_B ? {11'd0, imm5} : rf[Read_Addr_B];
        if (SUB || SBB)
            dp_s = {1'b0, dp_a} + {1'b0, ~dp_b} + (SUB ? 17'd1 : {16'd0, Pre_C});
        else
            dp_s = {1'b0, dp_a} + {1'b0, dp_b} + {16'd0, Pre_C};
        Y = dp_s[15:0];
        C = dp_s[16];
        Z = (dp_s[15:0] == 16'd0);
        N = dp_s[15];
        if (SUB || SBB)
            V = (dp_a[15] != dp_b[15]) && (dp_s[15] != dp_a[15]);
        else
            V = (dp_a[15] == dp_b[15]) && (dp_s[15] != dp_a[15]);
    end

    typedef struct {
        logic        wr;
        logic [2:0]  rd;
        logic [15:0] y;
        logic [3:0]  flg;
        logic        ill;
        logic        src;
        logic        pc;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] m_rf [8];
    logic [3:0]  m_flg;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    function automatic logic [15:0] enc(input int op, input int rd,
                                        input int ra, input int lo);
        return {4'(op), 3'(rd), 3'(ra), 6'(lo)};
    endfunction

    // Arithmetic reference written from integer semantics
    task automatic predict(input logic [15:0] ins, output exp_t e);
        logic [3:0]  op;
        logic [15:0] a, b, y;
        logic [16:0] s;
        logic        c;
        int          sa, sbv, r;
        op    = ins[15:12];
        c     = m_flg[3];
        e.ill = (op > 4'd6);
        e.src = (op == 4'd4) || (op == 4'd5);
        e.pc  = ((op == 4'd1) || (op == 4'd3)) ? c : 1'b0;
        e.rd  = ins[11:9];
        e.wr  = (op <= 4'd5);
        a     = m_rf[ins[8:6]];
        b     = e.src ? {11'd0, ins[4:0]} : m_rf[ins[5:3]];
        sa    = int'($signed(a));
        sbv   = int'($signed(b));
        case (op)
            4'd0, 4'd4: begin s = {1'b0, a} + {1'b0, b}; r = sa + sbv; end
            4'd1: begin
                s = {1'b0, a} + {1'b0, b} + {16'd0, c};
                r = sa + sbv + int'(c);
            end
            4'd3: begin
                s = {1'b0, a} + 17'h0FFFF - {1'b0, b} + {16'd0, c};
                r = sa - sbv - (1 - int'(c));
            end
            default: begin s = {1'b0, a} + 17'h10000 - {1'b0, b}; r = sa - sbv; end
        endcase
        y    = s[15:0];
        e.y  = y;
        if (!e.ill) m_flg = {s[16], y == 16'd0, y[15], (r > 32767) || (r < -32768)};
        e.flg = m_flg;
        if (e.wr) m_rf[e.rd] = y;
    endtask

    task automatic preload(input int a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1;
        pl_a  = 3'(a);
        pl_d  = d;
        m_rf[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic run(input logic [15:0] ins, input bit hold);
        exp_t e, g;
        int   n, acc;
        n = 0;
        @(negedge clk);
        while (!ibus.instr_ready && n < 10) begin @(negedge clk); n++; end
        chk("ready_wait", 32'(ibus.instr_ready), 32'd1);
        predict(ins, e);
        sb.push_back(e);
        ibus.instr_valid = 1'b1;
        ibus.instr = ins;
        @(negedge clk);
        acc = cyc;
        if (!hold) ibus.instr_valid = 1'b0;
        ibus.instr = 16'($urandom);
        chk("exec_busy", 32'(ibus.instr_ready), 32'd0);
        chk("exec_src", 32'(Src_ALU_B), 32'(e.src));
        chk("exec_prec", 32'(Pre_C), 32'(e.pc));
        chk("exec_ra", 32'(Read_Addr_A), 32'(ins[8:6]));
        n = 0;
        while (!done && n < 8) begin @(negedge clk); n++; end
        chk("done_seen", 32'(done), 32'd1);
        g = e;
        if (sb.size() != 0) g = sb.pop_front();
        else chk("sb_empty", 32'(sb.size()), 32'd1);
        chk("latency", 32'(cyc - acc), 32'd1);
        chk("wb_busy", 32'(ibus.instr_ready), 32'd0);
        chk("wb_we", 32'(Write_En), 32'(g.wr));
        if (g.wr) begin
            chk("wb_addr", 32'(Write_Addr), 32'(g.rd));
            chk("wb_data", 32'(Write_Data), 32'(g.y));
        end
        chk("wb_illegal", 32'(illegal), 32'(g.ill));
        @(negedge clk);
        chk("flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'(g.flg));
        chk("ready_back", 32'(ibus.instr_ready), 32'd1);
        chk("done_pulse", 32'(done), 32'd0);
        if (hold) begin
            ibus.instr_valid = 1'b0;
            @(negedge clk);
            chk("no_reaccept", 32'(ibus.instr_ready), 32'd1);
        end
    endtask

    initial begin
        ibus.instr_valid = 1'b0;
        ibus.instr = '0;
        pl_en = 1'b0;
        pl_a  = '0;
        pl_d  = '0;
        m_flg = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ibus.instr_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(Write_En), 32'd0);
        chk("rst_ctl", 32'({ADC, SUB, SBB, Pre_C, Src_ALU_B}), 32'd0);
        chk("rst_wdata", 32'(Write_Data), 32'd0);
        chk("rst_flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
        for (int i = 0; i < 8; i++) preload(i, 16'd0);
        rst_n = 1'b1;

        preload(0, 16'h1234);
        preload(1, 16'h2345);
        run(enc(0, 2, 0, 1 << 3), 1'b0);
        chk("add_r2", 32'(rf[2]), 32'h3579);

        preload(0, 16'hFFFF);
        preload(1, 16'h0001);
        run(enc(0, 2, 0, 1 << 3), 1'b0);
        chk("add_cz", 32'({flag_c, flag_z}), 32'b11);
        preload(0, 16'h0000);
        preload(1, 16'h0000);
        run(enc(1, 3, 0, 1 << 3), 1'b0);
        chk("adc_r3", 32'(rf[3]), 32'h0001);

        preload(0, 16'h2345);
        preload(1, 16'h1234);
        run(enc(2, 4, 0, 1 << 3), 1'b0);
        chk("sub_r4", 32'(rf[4]), 32'h1111);
        chk("sub_c", 32'(flag_c), 32'd1);
        run(enc(6, 5, 1, 0 << 3), 1'b0);
        chk("cmp_cn", 32'({flag_c, flag_n}), 32'b01);

        preload(0, 16'h0005);
        run(enc(5, 6, 0, 5), 1'b0);
        chk("subi_r6", 32'(rf[6]), 32'h0000);
        chk("subi_z", 32'(flag_z), 32'd1);

        run(enc(3, 7, 0, 1 << 3), 1'b0);
        run(enc(15, 2, 1, 9), 1'b1);
        chk("ill_r2", 32'(rf[2]), 32'(m_rf[2]));

        // Reset asserted while the DUT is in writeback
        @(negedge clk);
        ibus.instr_valid = 1'b1;
        ibus.instr = enc(0, 3, 0, 1 << 3);
        @(negedge clk);
        ibus.instr_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_wb_we", 32'(Write_En), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_wb_we", 32'(Write_En), 32'd0);
        chk("rst_wb_done", 32'(done), 32'd0);
        chk("rst_wb_flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
        chk("rst_wb_ready", 32'(ibus.instr_ready), 32'd1);
        m_flg = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_no_write", 32'(rf[3]), 32'(m_rf[3]));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(ibus.instr_ready), 32'd1);
        run(enc(0, 4, 0, 1 << 3), 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
